taxi_eth_frame_gen: RTL and testbench

//  Ethernet test-frame transmitter: the source end of the MAC TX AXI-Stream interface (feeds s_axis_tx).

---
 rtl/taxi_eth_frame_gen.sv | 198 +++++++++++++++++++
 tb/tb_taxi_eth_frame_gen.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/taxi_eth_frame_gen.sv
`default_nettype none
// ============================================================================
// Module   : taxi_eth_frame_gen
// Brief    : Ethernet test-frame source for a MAC TX AXI-Stream port. Emits
//            back-to-back frames of header + 32-bit sequence + byte-index
//            payload. FCS is left to the MAC.
// Revision : 1.0 - initial release
// ============================================================================
module taxi_eth_frame_gen #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W/8,
  parameter int ID_W   = 8,
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [ID_W-1:0]   m_axis_tid,
  output logic [0:0]        m_axis_tuser,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic [47:0]       cfg_eth_dst,
  input  logic [47:0]       cfg_eth_src,
  input  logic [15:0]       cfg_eth_type,
  input  logic [ID_W-1:0]   cfg_id,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic [CNT_W-1:0]  stat_frames,
  output logic [63:0]       stat_bytes
);

  localparam logic [0:0]       ST_IDLE = 1'b0;
  localparam logic [0:0]       ST_SEND = 1'b1;
  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(18);

  logic [0:0]        r_state;
  logic [LEN_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_count;
  logic [47:0]       r_dst;
  logic [47:0]       r_src;
  logic [15:0]       r_type;
  logic [ID_W-1:0]   r_id;
  logic [31:0]       r_seq;
  logic [CNT_W-1:0]  r_frames_run;
  logic              r_stop_pend;
  logic [LEN_W-1:0]  r_off;
  logic [DATA_W-1:0] r_tdata;
  logic [KEEP_W-1:0] r_tkeep;
  logic              r_tvalid;
  logic              r_tlast;
  logic              r_busy;
  logic [CNT_W-1:0]  r_stat_frames;
  logic [63:0]       r_stat_bytes;

  logic              w_idle;
  logic              w_hs;
  logic              w_end;
  logic [LEN_W-1:0]  w_cfg_len_c;
  logic [LEN_W-1:0]  w_b_len;
  logic [47:0]       w_b_dst;
  logic [47:0]       w_b_src;
  logic [15:0]       w_b_type;
  logic [31:0]       w_b_seq;
  logic [LEN_W-1:0]  w_b_off;
  logic [17:0][7:0]  w_hdr_p;
  logic [31:0]       w_n;
  logic [DATA_W-1:0] w_nxt_data;
  logic [KEEP_W-1:0] w_nxt_keep;
  logic              w_nxt_last;

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tkeep  = r_tkeep;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tid    = r_id;
  assign m_axis_tuser  = 1'b0;
  assign busy          = r_busy;
  assign stat_frames   = r_stat_frames;
  assign stat_bytes    = r_stat_bytes;

  // Select the frame parameters for the beat to load next: live cfg when a
  // run is starting, latched values otherwise; next frame restarts at offset 0.
  always_comb begin
    w_idle      = (r_state == ST_IDLE);
    w_hs        = r_tvalid && m_axis_tready;
    w_cfg_len_c = (cfg_len < MIN_LEN) ? MIN_LEN : cfg_len;
    w_b_len     = w_idle ? w_cfg_len_c  : r_len;
    w_b_dst     = w_idle ? cfg_eth_dst  : r_dst;
    w_b_src     = w_idle ? cfg_eth_src  : r_src;
    w_b_type    = w_idle ? cfg_eth_type : r_type;
    w_b_seq     = w_idle ? 32'd0 : (r_tlast ? r_seq + 32'd1 : r_seq);
    w_b_off     = w_idle ? '0 : (r_tlast ? '0 : r_off + LEN_W'(KEEP_W));
    w_end       = r_stop_pend || stop ||
                  ((r_count != '0) && ((r_frames_run + CNT_W'(1)) == r_count));
  end

  // Build the next beat: header bytes first (byte 0 is the MSB of the
  // concatenation), then the low byte of the frame offset as payload.
  always_comb begin
    w_hdr_p    = {w_b_dst, w_b_src, w_b_type, w_b_seq};
    w_nxt_data = '0;
    w_nxt_keep = '0;
    w_n        = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      w_n = 32'(w_b_off) + 32'(i);
      if (w_n < 32'(w_b_len)) begin
        w_nxt_keep[i] = 1'b1;
        if (w_n < 32'd18) begin
          w_nxt_data[8*i +: 8] = w_hdr_p[5'd17 - w_n[4:0]];
        end else begin
          w_nxt_data[8*i +: 8] = w_n[7:0];
        end
      end
    end
    w_nxt_last = (32'(w_b_off) + 32'(KEEP_W)) >= 32'(w_b_len);
  end

  // Run control, beat sequencing and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_len         <= MIN_LEN;
      r_count       <= '0;
      r_dst         <= '0;
      r_src         <= '0;
      r_type        <= '0;
      r_id          <= '0;
      r_seq         <= '0;
      r_frames_run  <= '0;
      r_stop_pend   <= 1'b0;
      r_off         <= '0;
      r_tdata       <= '0;
      r_tkeep       <= '0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_busy        <= 1'b0;
      r_stat_frames <= '0;
      r_stat_bytes  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state      <= ST_SEND;
            r_len        <= w_cfg_len_c;
            r_count      <= cfg_count;
            r_dst        <= cfg_eth_dst;
            r_src        <= cfg_eth_src;
            r_type       <= cfg_eth_type;
            r_id         <= cfg_id;
            r_seq        <= '0;
            r_frames_run <= '0;
            r_stop_pend  <= 1'b0;
            r_busy       <= 1'b1;
            r_tvalid     <= 1'b1;
            r_off        <= w_b_off;
            r_tdata      <= w_nxt_data;
            r_tkeep      <= w_nxt_keep;
            r_tlast      <= w_nxt_last;
          end
        end
        default: begin
          if (stop) begin
            r_stop_pend <= 1'b1;
          end
          if (w_hs) begin
            if (r_tlast) begin
              r_stat_frames <= r_stat_frames + CNT_W'(1);
              r_stat_bytes  <= r_stat_bytes + 64'(r_len);
              r_frames_run  <= r_frames_run + CNT_W'(1);
              r_seq         <= r_seq + 32'd1;
            end
            if (r_tlast && w_end) begin
              r_state     <= ST_IDLE;
              r_tvalid    <= 1'b0;
              r_tlast     <= 1'b0;
              r_busy      <= 1'b0;
              r_stop_pend <= 1'b0;
              r_off       <= '0;
            end else begin
              r_off   <= w_b_off;
              r_tdata <= w_nxt_data;
              r_tkeep <= w_nxt_keep;
              r_tlast <= w_nxt_last;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_taxi_eth_frame_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_taxi_eth_frame_gen
// Brief    : Directed self-checking bench for taxi_eth_frame_gen (64-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_taxi_eth_frame_gen;

  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;
  localparam int ID_W   = 8;
  localparam int LEN_W  = 16;
  localparam int CNT_W  = 32;
  localparam logic [47:0]     C_DST  = 48'h0A1B2C3D4E5F;
  localparam logic [47:0]     C_SRC  = 48'h020000000001;
  localparam logic [15:0]     C_TYPE = 16'h88B5;
  localparam logic [ID_W-1:0] C_ID   = 8'h5A;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [0:0]        tuser;
  logic [LEN_W-1:0]  cfg_len;
  logic [CNT_W-1:0]  cfg_count;
  logic              start;
  logic              stop;
  logic              busy;
  logic [CNT_W-1:0]  stat_frames;
  logic [63:0]       stat_bytes;

  taxi_eth_frame_gen #(
    .DATA_W(DATA_W), .KEEP_W(KEEP_W), .ID_W(ID_W), .LEN_W(LEN_W), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .rst(rst),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tlast(tlast), .m_axis_tid(tid),
    .m_axis_tuser(tuser),
    .cfg_len(cfg_len), .cfg_count(cfg_count), .cfg_eth_dst(C_DST),
    .cfg_eth_src(C_SRC), .cfg_eth_type(C_TYPE), .cfg_id(C_ID),
    .start(start), .stop(stop), .busy(busy),
    .stat_frames(stat_frames), .stat_bytes(stat_bytes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor state
  logic [7:0]        q[$];
  int                beats, lasts, mon_beat, mon_frames;
  int                gaps, keep_bad, stall_bad, stalls, side_bad;
  logic [7:0]        last_keep;
  bit                rand_rdy;
  bit                have_prev;
  logic [DATA_W-1:0] p_data;
  logic [KEEP_W-1:0] p_keep;
  logic              p_last;
  logic [ID_W-1:0]   p_id;

  task automatic clr();
    q.delete();
    beats = 0; lasts = 0; mon_beat = 0; mon_frames = 0;
    gaps = 0; keep_bad = 0; stall_bad = 0; stalls = 0; side_bad = 0;
    last_keep = '0; have_prev = 0;
  endtask

  // Drive tready for the coming edge, then record what that edge accepts.
  initial begin
    tready = 1'b0;
    clr();
    forever begin
      @(negedge clk);
      tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (have_prev) begin
        if (!tvalid || tdata != p_data || tkeep != p_keep || tlast != p_last || tid != p_id)
          stall_bad++;
      end
      have_prev = tvalid && !tready;
      if (have_prev) begin
        stalls++;
        p_data = tdata; p_keep = tkeep; p_last = tlast; p_id = tid;
      end
      if (tvalid) begin
        if (tid != C_ID || tuser != 1'b0) side_bad++;
      end
      if (tvalid && tready) begin
        beats++;
        for (int i = 0; i < KEEP_W; i++)
          if (tkeep[i]) q.push_back(tdata[8*i +: 8]);
        if (!tlast && tkeep != 8'hFF) keep_bad++;
        if (tlast) begin
          last_keep = tkeep;
          lasts++;
          mon_frames++;
          mon_beat = 0;
        end else begin
          mon_beat++;
        end
      end
      if (busy && !tvalid) gaps++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic run(input int len, input int count);
    cfg_len   = LEN_W'(len);
    cfg_count = CNT_W'(count);
    clr();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_lasts(input string tag, input int n);
    int c;
    c = 0;
    while (lasts < n && c < 3000) begin
      tick();
      c++;
    end
    chk({tag, "_timeout"}, 64'(c < 3000), 64'd1);
    tick();
    chk({tag, "_busy_off"}, 64'(busy), 64'd0);
    chk({tag, "_valid_off"}, 64'(tvalid), 64'd0);
  endtask

  function automatic logic [7:0] exp_byte(input int n, input int seq);
    logic [143:0] hdr;
    logic [31:0]  nn;
    hdr = {C_DST, C_SRC, C_TYPE, 32'(seq)};
    nn  = 32'(n);
    if (n < 18) return hdr[8*(17-n) +: 8];
    return nn[7:0];
  endfunction

  task automatic check_stream(input string tag, input int nfr, input int len);
    int l, mism;
    l = (len < 18) ? 18 : len;
    mism = 0;
    chk({tag, "_nbytes"}, 64'(q.size()), 64'(nfr * l));
    for (int f = 0; f < nfr; f++)
      for (int n = 0; n < l; n++)
        if (f*l + n < q.size())
          if (q[f*l + n] != exp_byte(n, f)) mism++;
    chk({tag, "_bytes"}, 64'(mism), 64'd0);
  endtask

  initial begin
    int c;
    rst = 1'b1; start = 1'b0; stop = 1'b0; rand_rdy = 0;
    cfg_len = 16'd64; cfg_count = 32'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_valid", 64'(tvalid), 64'd0);
    chk("rst_last", 64'(tlast), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frames", 64'(stat_frames), 64'd0);
    chk("rst_bytes", stat_bytes, 64'd0);

    // 1: 64-byte frames, two of them, full throughput
    run(64, 2);
    chk("t1_first_valid", 64'(tvalid), 64'd1);
    wait_lasts("t1", 2);
    chk("t1_beats", 64'(beats), 64'd16);
    chk("t1_lasts", 64'(lasts), 64'd2);
    chk("t1_keep", 64'(keep_bad), 64'd0);
    chk("t1_last_keep", 64'(last_keep), 64'hFF);
    chk("t1_gaps", 64'(gaps), 64'd0);
    chk("t1_side", 64'(side_bad), 64'd0);
    check_stream("t1", 2, 64);
    chk("t1_seq0", 64'({q[14], q[15], q[16], q[17]}), 64'h00000000);
    chk("t1_seq1", 64'({q[78], q[79], q[80], q[81]}), 64'h00000001);
    chk("t1_hdr0", 64'({q[0], q[5], q[6], q[12], q[13]}), 64'h0A5F0288B5);
    chk("t1_frames", 64'(stat_frames), 64'd2);
    chk("t1_bytes", stat_bytes, 64'd128);

    // 2: non-multiple length
    run(61, 1);
    wait_lasts("t2", 1);
    chk("t2_beats", 64'(beats), 64'd8);
    chk("t2_last_keep", 64'(last_keep), 64'h1F);
    chk("t2_b60", 64'(q[60]), 64'h3C);
    check_stream("t2", 1, 61);
    chk("t2_bytes", stat_bytes, 64'd189);

    // 3: short length is clamped to 18
    run(5, 1);
    wait_lasts("t3", 1);
    chk("t3_beats", 64'(beats), 64'd3);
    chk("t3_last_keep", 64'(last_keep), 64'h03);
    chk("t3_b17", 64'(q[17]), 64'h00);
    check_stream("t3", 1, 5);
    chk("t3_bytes", stat_bytes, 64'd207);

    // 4: random backpressure
    rand_rdy = 1;
    run(64, 2);
    wait_lasts("t4", 2);
    rand_rdy = 0;
    chk("t4_stall_stable", 64'(stall_bad), 64'd0);
    chk("t4_stalled", 64'(stalls > 0), 64'd1);
    chk("t4_beats", 64'(beats), 64'd16);
    chk("t4_gaps", 64'(gaps), 64'd0);
    check_stream("t4", 2, 64);
    chk("t4_frames", 64'(stat_frames), 64'd6);
    chk("t4_bytes", stat_bytes, 64'd335);

    // 5: continuous run, cfg change and start ignored mid-run, stop in frame 3
    run(64, 0);
    c = 0;
    while (!(mon_frames == 0 && mon_beat == 4) && c < 500) begin tick(); c++; end
    chk("t5_wait_a", 64'(c < 500), 64'd1);
    cfg_len = 16'd30;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    while (!(mon_frames == 2 && mon_beat == 3) && c < 500) begin tick(); c++; end
    chk("t5_wait_b", 64'(c < 500), 64'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_lasts("t5", 3);
    repeat (3) tick();
    chk("t5_stays_idle", 64'(tvalid), 64'd0);
    chk("t5_lasts", 64'(lasts), 64'd3);
    chk("t5_beats", 64'(beats), 64'd24);
    check_stream("t5", 3, 64);
    chk("t5_frames", 64'(stat_frames), 64'd9);
    chk("t5_bytes", stat_bytes, 64'd527);

    // 6: reset mid-frame, then a fresh run
    run(64, 0);
    c = 0;
    while (mon_beat != 3 && c < 500) begin tick(); c++; end
    chk("t6_wait", 64'(c < 500), 64'd1);
    rst = 1'b1;
    tick();
    chk("t6_valid", 64'(tvalid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_frames", 64'(stat_frames), 64'd0);
    chk("t6_bytes", stat_bytes, 64'd0);
    rst = 1'b0;
    tick();
    chk("t6_idle", 64'(tvalid), 64'd0);
    run(18, 1);
    wait_lasts("t6", 1);
    chk("t6_beats", 64'(beats), 64'd3);
    chk("t6_seq0", 64'({q[14], q[15], q[16], q[17]}), 64'h00000000);
    check_stream("t6", 1, 18);
    chk("t6_frames_after", 64'(stat_frames), 64'd1);
    chk("t6_bytes_after", stat_bytes, 64'd18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
